serial_frame_capture: RTL and testbench

- Downstream consumer of the serial bitstream that drives the shift-register chain's `sin` input; samples the same stream on the same clock.
- Hunts for a fixed sync pattern, then deframes fixed-width data words MSB-first.
- Verifies sync at every frame boundary, with a flywheel miss tolerance.
- Presents each word in parallel with a one-cycle valid strobe and a lock indicator.

---
 rtl/sfc_pkg.sv | 23 ++
 rtl/sync_match.sv | 31 +++
 rtl/serial_frame_capture.sv | 136 +++++++++++++
 tb/tb_serial_frame_capture.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfc_pkg.sv
// Shared types, default parameters and helpers for the serial frame capture block.
package sfc_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } sfc_state_e;

  localparam int unsigned SFC_WIDTH = 8;
  localparam int unsigned SFC_SYNC_LEN = 4;
  localparam logic [SFC_SYNC_LEN-1:0] SFC_SYNC_PATTERN = 4'b1011;
  localparam int unsigned SFC_MISS_LIMIT = 2;

  // Ceiling log2, floored at 1 so it can always size a vector.
  function automatic int unsigned sfc_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/sync_match.sv
// Serial history register plus comparator; match reflects the history after the current bit shifts in.
module sync_match
  import sfc_pkg::*;
#(
  parameter int unsigned               SYNC_LEN     = SFC_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]       SYNC_PATTERN = SFC_SYNC_PATTERN
) (
  input  logic clk,
  input  logic nrst,
  input  logic en,
  input  logic sin,
  output logic match
);

  // The incoming bit completes the window, so only SYNC_LEN-1 past bits are stored.
  logic [SYNC_LEN-2:0] hist_q;
  logic [SYNC_LEN-2:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (en) hist_d = (SYNC_LEN-1)'({hist_q, sin});
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  assign match = ({hist_q, sin} == SYNC_PATTERN);

endmodule

// File: rtl/serial_frame_capture.sv
// Sync-hunting deframer: finds the sync word, captures MSB-first data words and tracks lock with a flywheel.
module serial_frame_capture
  import sfc_pkg::*;
#(
  parameter int unsigned         WIDTH        = SFC_WIDTH,
  parameter int unsigned         SYNC_LEN     = SFC_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_LEN'(SFC_SYNC_PATTERN),
  parameter int unsigned         MISS_LIMIT   = SFC_MISS_LIMIT
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             sin,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             locked,
  output logic             sync_err
);

  localparam int unsigned BW = sfc_clog2(WIDTH);
  localparam int unsigned SW = sfc_clog2(SYNC_LEN);
  localparam int unsigned MW = sfc_clog2(MISS_LIMIT + 1);

  localparam logic [1:0] ST_HUNT  = 2'(HUNT);
  localparam logic [1:0] ST_DATA  = 2'(DATA);
  localparam logic [1:0] ST_CHECK = 2'(CHECK);

  logic [1:0]       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [SW-1:0]    sync_cnt_q, sync_cnt_d;
  logic [MW-1:0]    miss_cnt_q, miss_cnt_d;
  logic [WIDTH-2:0] data_q, data_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             locked_q, locked_d;
  logic             sync_err_q, sync_err_d;
  logic             sync_hit;

  sync_match #(
    .SYNC_LEN    (SYNC_LEN),
    .SYNC_PATTERN(SYNC_PATTERN)
  ) u_sync_match (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .sin  (sin),
    .match(sync_hit)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    sync_cnt_d   = sync_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    data_d       = data_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;
    if (en) begin
      case (state_q)
        ST_HUNT: begin
          locked_d = 1'b0;
          if (sync_hit) begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
          end
        end
        ST_DATA: begin
          // Only the partial word is stored; the final bit is taken straight from sin.
          data_d = (WIDTH-1)'({data_q, sin});
          if (bit_cnt_q == BW'(WIDTH - 1)) begin
            word_d       = {data_q, sin};
            word_valid_d = 1'b1;
            state_d      = ST_CHECK;
            sync_cnt_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
        ST_CHECK: begin
          if (sync_cnt_q == SW'(SYNC_LEN - 1)) begin
            if (sync_hit) begin
              locked_d   = 1'b1;
              miss_cnt_d = '0;
              state_d    = ST_DATA;
              bit_cnt_d  = '0;
            end else if ((32'(miss_cnt_q) + 32'd1) < MISS_LIMIT) begin
              miss_cnt_d = miss_cnt_q + MW'(1);
              state_d    = ST_DATA;
              bit_cnt_d  = '0;
            end else begin
              locked_d   = 1'b0;
              miss_cnt_d = '0;
              sync_err_d = 1'b1;
              state_d    = ST_HUNT;
            end
          end else begin
            sync_cnt_d = sync_cnt_q + SW'(1);
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_HUNT;
      bit_cnt_q    <= '0;
      sync_cnt_q   <= '0;
      miss_cnt_q   <= '0;
      data_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      sync_cnt_q   <= sync_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      data_q       <= data_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_serial_frame_capture.sv
// Self-checking bench for serial_frame_capture: directed scenarios plus a randomized stream against a frame-level model.
module tb_serial_frame_capture;

  localparam int unsigned W   = 8;
  localparam int unsigned SL  = 4;
  localparam logic [3:0]  PAT = 4'b1011;
  localparam int unsigned ML  = 2;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b0;
  logic         sin = 1'b0;
  logic [W-1:0] word;
  logic         word_valid;
  logic         locked;
  logic         sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Frame-level reference: a long bit history, a hunting flag and a position within the frame.
  logic [31:0]  m_sh;
  bit           m_hunting;
  int           m_pos;
  int           m_miss;
  bit           m_locked;
  logic [W-1:0] m_word;
  bit           m_valid;
  bit           m_err;

  serial_frame_capture #(
    .WIDTH       (W),
    .SYNC_LEN    (SL),
    .SYNC_PATTERN(PAT),
    .MISS_LIMIT  (ML)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .sin       (sin),
    .word      (word),
    .word_valid(word_valid),
    .locked    (locked),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_sh = '0; m_hunting = 1'b1; m_pos = 0; m_miss = 0;
    m_locked = 1'b0; m_word = '0; m_valid = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic b);
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_sh    = {m_sh[30:0], b};
    if (m_hunting) begin
      if (m_sh[SL-1:0] == PAT) begin
        m_hunting = 1'b0;
        m_pos     = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == W) begin
        m_valid = 1'b1;
        m_word  = m_sh[W-1:0];
      end else if (m_pos == W + SL) begin
        m_pos = 0;
        if (m_sh[SL-1:0] == PAT) begin
          m_locked = 1'b1; m_miss = 0;
        end else if (m_miss + 1 < ML) begin
          m_miss++;
        end else begin
          m_locked = 1'b0; m_miss = 0; m_err = 1'b1; m_hunting = 1'b1;
        end
      end
    end
  endtask

  // Drive one clock worth of input at the falling edge and sample just after the rising edge.
  task automatic step(input logic e, input logic b);
    @(negedge clk);
    en  = e;
    sin = b;
    @(posedge clk);
    #1;
    if (e) model_step(b);
    else begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    nrst = 1'b0; en = 1'b0; sin = 1'b0;
    model_reset();
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    n_checks++; if (word !== 8'h00) begin n_fail++; $display("FAIL rst_word got=%h exp=00", word); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rst_locked got=%b exp=0", locked); end
    step(1'b0, 1'b1);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", word_valid); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", sync_err); end
  endtask

  task automatic test_acquire();
    send(32'b0000_1011_1010010, 15);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL acq_early_valid got=%b exp=0", word_valid); end
    step(1'b1, 1'b1);
    n_checks++; if (word_valid !== 1'b1) begin n_fail++; $display("FAIL acq_valid got=%b exp=1", word_valid); end
    n_checks++; if (word !== 8'hA5) begin n_fail++; $display("FAIL acq_word got=%h exp=a5", word); end
    n_checks++; if (word !== m_word) begin n_fail++; $display("FAIL acq_model_word got=%h exp=%h", word, m_word); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL acq_locked got=%b exp=0", locked); end
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL acq_err got=%b exp=0", sync_err); end
  endtask

  task automatic test_lock();
    send(32'b101, 3);
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%b exp=0", locked); end
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL lock_valid_drop got=%b exp=0", word_valid); end
    step(1'b1, 1'b1);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_rise got=%b exp=1", locked); end
    send(32'b0011110, 7);
    step(1'b1, 1'b0);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'h3C) begin
      n_fail++; $display("FAIL lock_word got=%b/%h exp=1/3c", word_valid, word);
    end
    send(32'b1111, 4);
    n_checks++; if (word !== 8'h3C || word_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_hold got=%b/%h exp=0/3c", word_valid, word);
    end
  endtask

  task automatic test_flywheel();
    send(32'b0101010, 7);
    step(1'b1, 1'b1);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'h55) begin
      n_fail++; $display("FAIL fly_word got=%b/%h exp=1/55", word_valid, word);
    end
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL fly_locked got=%b exp=1", locked); end
    send(32'b000, 3);
    n_checks++; if (sync_err !== 1'b0 || locked !== 1'b1) begin
      n_fail++; $display("FAIL fly_pre_loss got=%b/%b exp=0/1", sync_err, locked);
    end
    step(1'b1, 1'b0);
    n_checks++; if (sync_err !== 1'b1) begin n_fail++; $display("FAIL loss_err got=%b exp=1", sync_err); end
    n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_locked got=%b exp=0", locked); end
    step(1'b1, 1'b1);
    n_checks++; if (sync_err !== 1'b0) begin n_fail++; $display("FAIL loss_err_pulse got=%b exp=0", sync_err); end
    send(32'b011_0101_1010, 11);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'h5A) begin
      n_fail++; $display("FAIL reacq_word got=%b/%h exp=1/5a", word_valid, word);
    end
  endtask

  task automatic test_enable_gaps();
    logic [W-1:0] held;
    pulse_reset();
    send(32'b1011_110, 7);
    held = word;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'($urandom_range(1)));
      n_checks++; if (word_valid !== 1'b0 || word !== held) begin
        n_fail++; $display("FAIL gap_hold i=%0d got=%b/%h exp=0/%h", i, word_valid, word, held);
      end
    end
    send(32'b0001, 4);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early got=%b exp=0", word_valid); end
    step(1'b1, 1'b1);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'hC3) begin
      n_fail++; $display("FAIL gap_word got=%b/%h exp=1/c3", word_valid, word);
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] frame;
    send(32'b1011_10101, 9);
    n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL ar_pre_locked got=%b exp=1", locked); end
    #2;
    nrst = 1'b0;
    #1;
    n_checks++; if (word !== 8'h00 || word_valid !== 1'b0 || locked !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL ar_outputs got=%h/%b/%b/%b exp=00/0/0/0", word, word_valid, locked, sync_err);
    end
    model_reset();
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    step(1'b0, 1'b0);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ar_release got=%b exp=0", word_valid); end
    frame = 32'b1011_1111_0000;
    for (int i = 11; i >= 1; i--) begin
      step(1'b1, frame[i]);
      n_checks++; if (word_valid !== 1'b0) begin
        n_fail++; $display("FAIL ar_spurious bit=%0d got=%b exp=0", 12 - i, word_valid);
      end
    end
    step(1'b1, frame[0]);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'hF0) begin
      n_fail++; $display("FAIL ar_word got=%b/%h exp=1/f0", word_valid, word);
    end
  endtask

  task automatic test_overlap();
    pulse_reset();
    send(32'b1011_0110_000, 11);
    step(1'b1, 1'b0);
    n_checks++; if (word_valid !== 1'b1 || word !== 8'h60) begin
      n_fail++; $display("FAIL ovl_word got=%b/%h exp=1/60", word_valid, word);
    end
    send(32'b0001, 3);
    n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL ovl_late got=%b exp=0", word_valid); end
  endtask

  task automatic test_random();
    logic [1:0]  q[$];
    logic [11:0] frame;
    logic [3:0]  syn;
    pulse_reset();
    for (int f = 0; f < 180; f++) begin
      if ($urandom_range(9) == 0)
        for (int j = 0; j < 3; j++) q.push_back({1'b1, 1'($urandom_range(1))});
      syn   = ($urandom_range(3) != 0) ? PAT : 4'($urandom_range(15));
      frame = {syn, 8'($urandom)};
      for (int i = 11; i >= 0; i--) begin
        if ($urandom_range(5) == 0) q.push_back({1'b0, 1'($urandom_range(1))});
        q.push_back({1'b1, frame[i]});
      end
    end
    for (int c = 0; c < q.size(); c++) begin
      step(q[c][1], q[c][0]);
      n_checks++; if (word_valid !== m_valid) begin
        n_fail++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, word_valid, m_valid);
      end
      n_checks++; if (word !== m_word) begin
        n_fail++; $display("FAIL rnd_word cyc=%0d got=%h exp=%h", c, word, m_word);
      end
      n_checks++; if (locked !== m_locked) begin
        n_fail++; $display("FAIL rnd_locked cyc=%0d got=%b exp=%b", c, locked, m_locked);
      end
      n_checks++; if (sync_err !== m_err) begin
        n_fail++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, sync_err, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_lock();
    test_flywheel();
    test_enable_gaps();
    test_async_reset();
    test_overlap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
